// File: rtl/pw_pkg.sv
// Shared types and default constants for the password verifier.
package pw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_OPEN,
    ST_FAIL,
    ST_LOCKED
  } pw_state_t;

  localparam logic [15:0] DEFAULT_PW  = 16'h8421;
  localparam int          OPEN_CYCLES = 8;
  localparam int          LOCK_CYCLES = 16;
  localparam int          MAX_TRIES   = 3;

  // Counter width able to hold the larger of the two reload values (count-1).
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pw_timer.sv
// Loadable down-counter shared by the OPEN window and the LOCKED lockout.
module pw_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load has priority over counting; the counter parks at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pw_verify.sv
// Keypad password verifier: compare, timed unlock, password change and lockout.
module pw_verify #(
  parameter int          OPEN_CYCLES = pw_pkg::OPEN_CYCLES,
  parameter int          LOCK_CYCLES = pw_pkg::LOCK_CYCLES,
  parameter int          MAX_TRIES   = pw_pkg::MAX_TRIES,
  parameter logic [15:0] DEFAULT_PW  = pw_pkg::DEFAULT_PW
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] IB0,
  input  logic [3:0] IB1,
  input  logic [3:0] IB2,
  input  logic [3:0] IB3,
  input  logic       Enter,
  input  logic       Set_mode,
  output logic       Unlock,
  output logic       Fail,
  output logic       Lock,
  output logic       Saved,
  output logic [1:0] Attempts
);

  import pw_pkg::*;

  localparam int            TW        = timer_width(OPEN_CYCLES, LOCK_CYCLES);
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);

  pw_state_t     state_q, state_next;
  logic          enter_d, enter_edge;
  logic [15:0]   key_in, cap_reg, pw_reg;
  logic [1:0]    attempts_q, attempts_next;
  logic          timer_load, timer_en, timer_zero;
  logic [TW-1:0] timer_load_value;
  logic          cap_en, pw_store;

  assign key_in     = {IB3, IB2, IB1, IB0};
  assign enter_edge = Enter & ~enter_d;
  assign Attempts   = attempts_q;

  pw_timer #(.WIDTH(TW)) u_timer (
    .clk        (CLK),
    .rst        (RST),
    .load       (timer_load),
    .load_value (timer_load_value),
    .enable     (timer_en),
    .zero       (timer_zero)
  );

  // Next-state, timer control and data-path enables for the verifier FSM.
  always_comb begin
    state_next       = state_q;
    attempts_next    = attempts_q;
    timer_load       = 1'b0;
    timer_load_value = '0;
    timer_en         = 1'b0;
    cap_en           = 1'b0;
    pw_store         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enter_edge) begin
          cap_en     = 1'b1;
          state_next = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (cap_reg == pw_reg) begin
          attempts_next    = '0;
          timer_load       = 1'b1;
          timer_load_value = OPEN_LOAD;
          state_next       = ST_OPEN;
        end else if ((int'(attempts_q) + 1) < MAX_TRIES) begin
          attempts_next = attempts_q + 2'd1;
          state_next    = ST_FAIL;
        end else begin
          timer_load       = 1'b1;
          timer_load_value = LOCK_LOAD;
          state_next       = ST_LOCKED;
        end
      end
      ST_OPEN: begin
        if (enter_edge && Set_mode) begin
          pw_store         = 1'b1;
          timer_load       = 1'b1;
          timer_load_value = OPEN_LOAD;
        end else if (timer_zero) begin
          state_next = ST_IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_FAIL: begin
        state_next = ST_IDLE;
      end
      ST_LOCKED: begin
        if (timer_zero) begin
          attempts_next = '0;
          state_next    = ST_IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, edge history, captured key, stored password and mismatch count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      enter_d    <= 1'b1;
      cap_reg    <= '0;
      pw_reg     <= DEFAULT_PW;
      attempts_q <= '0;
    end else begin
      state_q    <= state_next;
      enter_d    <= Enter;
      attempts_q <= attempts_next;
      if (cap_en) begin
        cap_reg <= key_in;
      end
      if (pw_store) begin
        pw_reg <= key_in;
      end
    end
  end

  // Registered status outputs, decoded from the state being entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Unlock <= 1'b0;
      Fail   <= 1'b0;
      Lock   <= 1'b0;
      Saved  <= 1'b0;
    end else begin
      Unlock <= (state_next == ST_OPEN);
      Fail   <= (state_next == ST_FAIL);
      Lock   <= (state_next == ST_LOCKED);
      Saved  <= pw_store;
    end
  end

endmodule

// File: doc/pw_verify.md
PW_VERIFY -- requirements
Module: pw_verify

Interface
REQ-001 Parameter OPEN_CYCLES, default 8: number of cycles Unlock stays high.
REQ-002 Parameter LOCK_CYCLES, default 16: number of cycles of lockout.
REQ-003 Parameter MAX_TRIES, default 3: consecutive mismatches that trigger lockout.
REQ-004 Parameter DEFAULT_PW, default 16'h8421: reset password, packed {IB3,IB2,IB1,IB0}.
REQ-005 CLK  in  1: single clock; all state changes on rising edge.
REQ-006 RST  in  1: synchronous, active-high reset.
REQ-007 IB0..IB3  in  4 each: entered key codes; IB0 newest, IB3 oldest.
REQ-008 Enter  in  1: level request; only the rising edge acts.
REQ-009 Set_mode  in  1: when high, an Enter edge in OPEN stores a new password.
REQ-010 Unlock  out  1: high while in OPEN.
REQ-011 Fail  out  1: one-cycle pulse per mismatch that does not cause lockout.
REQ-012 Lock  out  1: high while in LOCKED.
REQ-013 Saved  out  1: one-cycle pulse when a new password is stored.
REQ-014 Attempts  out  2: current consecutive-mismatch count.

Function
REQ-015 Edge detection: edge = Enter & ~enter_d; enter_d is a register.
REQ-016 States: IDLE, COMPARE, OPEN, FAIL, LOCKED; all outputs come from registers.
REQ-017 IDLE + edge: capture {IB3..IB0} into cap_reg; next state COMPARE.
REQ-018 IDLE + Set_mode high: an edge still runs a compare; storing a password requires OPEN.
REQ-019 COMPARE, cap_reg == pw_reg: go to OPEN, clear Attempts, load timer with OPEN_CYCLES-1.
REQ-020 COMPARE, mismatch with Attempts+1 < MAX_TRIES: increment Attempts, go to FAIL.
REQ-021 COMPARE, mismatch with Attempts+1 == MAX_TRIES: go to LOCKED, load timer with LOCK_CYCLES-1.
REQ-022 Attempts saturates at MAX_TRIES-1 and never wraps.
REQ-023 FAIL lasts exactly one cycle, then IDLE; Fail = 1 only in FAIL.
REQ-024 Latency: Enter first sampled high at edge N gives COMPARE at N, and Unlock/Fail/Lock asserted after edge N+1.
REQ-025 OPEN: timer decrements each cycle; at 0 go to IDLE, so Unlock is high exactly OPEN_CYCLES cycles.
REQ-026 OPEN + edge + Set_mode: pw_reg <= {IB3..IB0}, Saved pulses next cycle, and the timer reloads with OPEN_CYCLES-1.
REQ-027 OPEN + edge + ~Set_mode: ignored.
REQ-028 If an edge with Set_mode coincides with timer == 0, the store wins and OPEN is extended.
REQ-029 LOCKED: Enter is ignored; timer decrements each cycle; at 0 clear Attempts and go to IDLE, so Lock is high exactly LOCK_CYCLES cycles.
REQ-030 Edges arriving in COMPARE or FAIL are dropped, not queued.
REQ-031 The new password takes effect for the first compare after the store.

Reset
REQ-032 While RST=1 the next edge sets: state IDLE, pw_reg = DEFAULT_PW, cap_reg = 0, timer = 0, Attempts = 0, Unlock/Fail/Lock/Saved = 0.
REQ-033 enter_d resets to 1, so Enter held high across reset release causes no request.
REQ-034 RST asserted in any state, including OPEN or LOCKED mid-count, takes precedence, aborts the operation and restores DEFAULT_PW.

Structure
REQ-035 Shared package pw_pkg: state enum pw_state_t and default constants (DEFAULT_PW, OPEN_CYCLES, LOCK_CYCLES, MAX_TRIES).
REQ-036 One sub-module pw_timer: loadable down-counter with load, enable and zero flag, shared by OPEN and LOCKED; width sized to max(OPEN_CYCLES, LOCK_CYCLES).

Verification
REQ-037 Reset, then IB3..IB0 = 8,4,2,1, then Enter edge -> Unlock high 2 cycles later for exactly 8 cycles; Attempts = 0.
REQ-038 Three edges with IB = 1,1,1,1 -> Fail pulses twice with Attempts 1 then 2; third edge -> Lock high 16 cycles, Enter ignored, then Attempts = 0.
REQ-039 Unlock, then Set_mode=1 with IB = 2,2,4,4 and an edge -> Saved pulse; after timeout, 8,4,2,1 fails and 2,2,4,4 unlocks.
REQ-040 Enter held high through RST release -> no COMPARE and no outputs; a later low-high edge is accepted.
REQ-041 RST asserted in cycle 5 of LOCKED and in cycle 3 of OPEN -> next cycle all outputs 0, state IDLE, DEFAULT_PW unlocks.
REQ-042 Set_mode edge landing on the final OPEN cycle -> Saved pulses and Unlock continues 8 more cycles.
